// File: rtl/coin_pulse_validator_pkg.sv
// Shared definitions for the coin pulse validator: FSM state encoding and
// reject-counter sizing.
package coin_pulse_validator_pkg;

   typedef enum logic [1:0] {
      WAIT_LOW = 2'd0,
      IDLE     = 2'd1,
      MEASURE  = 2'd2,
      HOLDOFF  = 2'd3
   } state_t;

   localparam int REJ_CNT_W = 8;
   localparam logic [REJ_CNT_W-1:0] REJ_CNT_MAX = '1;

endpackage

// File: rtl/sync_2ff.sv
// One-bit two-flop synchroniser with synchronous active-low reset to 0.
// Reusable by any asynchronous input channel.
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic i_async,
   output logic o_sync
);

   logic r_s1;
   logic r_s2;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
      end else begin
         r_s1 <= i_async;
         r_s2 <= r_s1;
      end
   end

   assign o_sync = r_s2;

endmodule

// File: rtl/coin_pulse_validator.sv
// Qualifies a raw coin-sensor line by high-pulse width and emits one-cycle
// coin/reject strobes. Define COIN_REJECT_CNT_EN to add the reject_count port.
module coin_pulse_validator
   import coin_pulse_validator_pkg::*;
#(
   parameter int MIN_W = 50000,
   parameter int MAX_W = 2000000,
   parameter int GAP   = 100000,
   parameter int CNT_W = $clog2(MAX_W + 2)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sensor_in,
   output logic coin_pulse,
   output logic reject_pulse,
   output logic busy
`ifdef COIN_REJECT_CNT_EN
   ,
   output logic [REJ_CNT_W-1:0] reject_count
`endif
);

   localparam logic [CNT_W-1:0] L_MIN_W = CNT_W'(MIN_W);
   localparam logic [CNT_W-1:0] L_MAX_W = CNT_W'(MAX_W);
   localparam logic [CNT_W-1:0] L_GAP   = CNT_W'(GAP);
   localparam logic [CNT_W-1:0] L_ONE   = CNT_W'(1);

   logic             w_sensorSync;
   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_gap;
   logic [1:0]       r_settle;
   logic             r_coinPulse;
   logic             r_rejectPulse;

   sync_2ff u_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_async (sensor_in),
      .o_sync  (w_sensorSync)
   );

   // The synchroniser's reset zeros are not real line samples, so WAIT_LOW
   // only trusts s2 once two post-reset edges have filled it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_settle <= 2'b00;
      end else begin
         r_settle <= {r_settle[0], 1'b1};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state       <= WAIT_LOW;
         r_cnt         <= '0;
         r_gap         <= '0;
         r_coinPulse   <= 1'b0;
         r_rejectPulse <= 1'b0;
      end else begin
         r_coinPulse   <= 1'b0;
         r_rejectPulse <= 1'b0;
         case (r_state)
            WAIT_LOW: begin
               if (r_settle[1] && !w_sensorSync) begin
                  r_state <= IDLE;
               end
            end
            IDLE: begin
               if (w_sensorSync) begin
                  r_state <= MEASURE;
                  r_cnt   <= L_ONE;
               end
            end
            MEASURE: begin
               if (w_sensorSync) begin
                  // Reaching MAX_W with the line still high means this is the
                  // (MAX_W+1)th high cycle: reject now, ignore the later fall.
                  if (r_cnt == L_MAX_W) begin
                     r_rejectPulse <= 1'b1;
                     r_state       <= WAIT_LOW;
                  end else begin
                     r_cnt <= r_cnt + L_ONE;
                  end
               end else begin
                  if (r_cnt >= L_MIN_W) begin
                     r_coinPulse <= 1'b1;
                  end else begin
                     r_rejectPulse <= 1'b1;
                  end
                  r_state <= HOLDOFF;
                  r_gap   <= L_GAP;
               end
            end
            HOLDOFF: begin
               r_gap <= r_gap - L_ONE;
               if (r_gap == L_ONE) begin
                  r_state <= WAIT_LOW;
               end
            end
            default: begin
               r_state <= WAIT_LOW;
            end
         endcase
      end
   end

   assign coin_pulse   = r_coinPulse;
   assign reject_pulse = r_rejectPulse;
   assign busy         = (r_state != IDLE);

`ifdef COIN_REJECT_CNT_EN
   logic [REJ_CNT_W-1:0] r_rejectCount;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rejectCount <= '0;
      end else if (r_rejectPulse && (r_rejectCount != REJ_CNT_MAX)) begin
         r_rejectCount <= r_rejectCount + REJ_CNT_W'(1);
      end
   end

   assign reject_count = r_rejectCount;
`endif

endmodule

// File: doc/coin_pulse_validator.md
Name: coin_pulse_validator

Overview:
- Upstream front-end for each coin channel. Qualifies a raw coin-sensor line and emits a single-cycle coin strobe to the per-denomination counter.
- Synchronises the asynchronous input, measures the high-pulse width and rejects pulses that are too short, too long or stuck high.
- Enforces a post-coin hold-off window so that sensor chatter after a coin produces no further events.
- One instance per denomination channel.

Parameters:
- MIN_W, 50000: minimum accepted high width, in clk cycles (must be ≥1).
- MAX_W, 2000000: maximum accepted high width, in clk cycles (must be ≥ MIN_W).
- GAP, 100000: hold-off cycles after a pulse ends (must be ≥1).
- CNT_W, $clog2(MAX_W+2): width of the width counter and the hold-off counter.

Ports:
- clk, input, 1: system clock; single clock domain.
- rst_n, input, 1: reset, synchronous, active-low.
- sensor_in, input, 1: raw asynchronous coin-sensor line, active-high.
- coin_pulse, output, 1: one-cycle strobe for an accepted coin.
- reject_pulse, output, 1: one-cycle strobe for a rejected pulse.
- busy, output, 1: high whenever state ≠ IDLE.
- reject_count, output, 8: only present with COIN_REJECT_CNT_EN.

Behaviour:
- Synchroniser: 2-FF, s1 then s2, both reset to 0. s2 lags sensor_in by 2 edges. Width = number of cycles s2 is high.
- Reset (rst_n low at a clk edge):
  - state ← WAIT_LOW, counters ← 0.
  - coin_pulse, reject_pulse ← 0; busy = 1.
  - A reset mid-pulse discards that pulse; no strobe is emitted.
- States and transitions:
  - WAIT_LOW: s2=0 → IDLE. Prevents a line that is already high, or stuck high, from counting.
  - IDLE: s2=1 → MEASURE, cnt←1.
  - MEASURE, s2=1, cnt<MAX_W: cnt←cnt+1.
  - MEASURE, s2=1, cnt==MAX_W: this is the (MAX_W+1)th high cycle. reject_pulse←1, → WAIT_LOW. The reject is issued while the line is still high, and no strobe is issued on the later fall.
  - MEASURE, s2=0: cnt≥MIN_W → coin_pulse←1, otherwise reject_pulse←1. Then → HOLDOFF with gap←GAP.
  - HOLDOFF: gap←gap−1; s2 is ignored. gap==1 → WAIT_LOW. A line still high at expiry must fall before the next edge is accepted.
- Output timing:
  - Strobes are registered and last exactly 1 cycle.
  - coin_pulse and reject_pulse are never high together.
  - Strobe latency: 2 clk edges after the edge that first samples sensor_in low. Overall latency is 3 edges counting the FSM register.
- Boundaries:
  - Width MIN_W and width MAX_W are both accepted.
  - Widths MIN_W−1 and MAX_W+1 are rejected.
  - Counters never wrap: cnt saturates logically via the MAX_W check; gap stops at 1.

Optional Feature:
- COIN_REJECT_CNT_EN defined:
  - reject_count port exists.
  - 8-bit counter incremented on every reject_pulse cycle, saturating at 255.
  - Cleared only by reset (reset value 0).
- Not defined: the port and its register are absent; all other behaviour is identical.

Decomposition:
- Shared package/header holds:
  - State encoding constants: WAIT_LOW=2'd0, IDLE=2'd1, MEASURE=2'd2, HOLDOFF=2'd3.
  - Reject-counter width constant (8).
- One natural sub-module: sync_2ff (1-bit two-flop synchroniser, synchronous active-low reset to 0). Reused later by other input channels.
- The FSM and counters stay in coin_pulse_validator.

Test Plan:
All tests use MIN_W=4, MAX_W=10, GAP=6, and start with rst_n low for 3 cycles, sensor_in=0.
- Nominal coin: sensor_in high for 6 cycles → exactly one coin_pulse, 3 edges after sensor_in falls. reject_pulse stays 0. busy is high from MEASURE through HOLDOFF, then returns to 0.
- Short pulse: high for 3 cycles → one reject_pulse, no coin_pulse.
- Width boundaries:
  - High 4 cycles → coin.
  - High 10 cycles → coin.
  - High 11+ cycles → reject_pulse during the high phase. Nothing further on the fall, and busy stays high until the line falls.
- Hold-off:
  - 6-cycle coin, low 2 cycles, then 6-cycle chatter pulse → only the first coin_pulse.
  - A fresh 6-cycle pulse after hold-off expires and the line has been low → second coin_pulse.
- Reset cases:
  - sensor_in high when rst_n rises, then falls → no strobe.
  - Next valid pulse → coin.
  - rst_n pulsed low mid-MEASURE → no strobe for that pulse.
- COIN_REJECT_CNT_EN: 300 consecutive 2-cycle pulses, each separated by 10 low cycles → reject_count reads 255 at the end. A subsequent valid coin leaves it at 255.
